// File: rtl/epw22_req_arbiter.sv
// epw22_req_arbiter: round-robin owner arbiter for the shared EPW22 bus.
// Define EPW22_ARB_TIMEOUT_EN to build in the grant-hold watchdog.
module epw22_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         grant,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    timeout
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            timeout_q, timeout_d;

  logic [IW-1:0]   sel;
  logic            found;
  logic            own_done;
  logic            own_drop;
  logic            expire;

`ifdef EPW22_ARB_TIMEOUT_EN
  logic [9:0] hold_q, hold_d;

  // Hold counter: cleared on grant, counts cycles spent in OWN.
  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE && found) begin
      hold_d = '0;
    end else if (state_q == OWN) begin
      hold_d = hold_q + 10'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign expire = (state_q == OWN) &&
                  (hold_q == 10'(MAX_HOLD - 1));
`else
  // Watchdog compiled out: a grant never expires.
  assign expire = (MAX_HOLD < 0);
`endif

  // Find the first requester at or above rr_q, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign own_done = done[id_q];
  assign own_drop = !req[id_q];

  // Next-state, grant and pointer logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    rr_d      = rr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = OWN;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          id_d         = sel;
        end
      end
      OWN: begin
        if (own_done || own_drop || expire) begin
          state_d   = RELEASE;
          grant_d   = '0;
          timeout_d = expire && !own_done && !own_drop;
          if (id_q == IW'(NREQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = id_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      rr_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_valid ? id_q : '0;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_epw22_req_arbiter.sv
// tb_epw22_req_arbiter: directed table, watchdog sequences and
// randomized traffic against a behavioural owner/pointer model.
module tb_epw22_req_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

`ifdef EPW22_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  epw22_req_arbiter #(
    .NREQ    (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout    (timeout)
  );

  // Reference: who owns the bus, blank cycles left, pointer, hold age.
  int m_owner = -1;
  int m_cool  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int j = 0; j < N; j++) begin
      d = (j - p + N) % N;
      if (r[j] && d < bestd) begin
        best  = j;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_update();
    bit dn;
    bit dr;
    bit ex;
    if (reset) begin
      m_owner = -1;
      m_cool  = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else if (m_owner >= 0) begin
      m_held = m_held + 1;
      dn = done[m_owner];
      dr = !req[m_owner];
      ex = WD && (m_held >= MH);
      m_to = ex && !dn && !dr;
      if (dn || dr || ex) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool = 0;
      m_to   = 1'b0;
    end else begin
      m_to    = 1'b0;
      m_owner = pick(req, m_ptr);
      m_held  = 0;
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] eg,
                       input logic [1:0] eid, input logic eto);
    logic ev;
    ev = |eg;
    checks = checks + 1;
    if (grant !== eg || grant_id !== eid ||
        grant_valid !== ev || timeout !== eto) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t got g=%b id=%0d v=%b to=%b want g=%b id=%0d v=%b to=%b",
               name, $time, grant, grant_id, grant_valid, timeout,
               eg, eid, ev, eto);
    end
  endtask

  task automatic check_model(input string name);
    logic [N-1:0] eg;
    logic [1:0]   eid;
    eg  = '0;
    eid = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eid = 2'(m_owner);
    end
    check(name, eg, eid, m_to);
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [N-1:0] dn);
    reset = r;
    req   = rq;
    done  = dn;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] dn;
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] dn;

    reset = 1'b1;
    req   = '0;
    done  = '0;

    tv.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b0010, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0});
    tv.push_back('{1'b0, 4'b1010, 4'b1000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b1110, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0});
    tv.push_back('{1'b1, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].rq, tv[i].dn);
      check($sformatf("vec%0d", i), tv[i].g, tv[i].id, tv[i].to);
    end

    // Requester 1 holds the bus and never signals done.
    step(1'b1, 4'b0000, 4'b0000);
    check("wd_reset", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 4'b0000);
    check("wd_grant", 4'b0010, 2'd1, 1'b0);
`ifdef EPW22_ARB_TIMEOUT_EN
    for (int k = 2; k <= MH; k++) begin
      step(1'b0, 4'b0010, 4'b0000);
      check($sformatf("wd_hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step(1'b0, 4'b0010, 4'b0000);
    check("wd_revoke", 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0010, 4'b0000);
    check("wd_pulse_end", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 4'b0000);
    check("wd_regrant", 4'b0010, 2'd1, 1'b0);
    for (int k = 2; k <= MH; k++) begin
      step(1'b0, 4'b0010, 4'b0000);
      check($sformatf("col_hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step(1'b0, 4'b0010, 4'b0010);
    check("col_release", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    check("col_idle", 4'b0000, 2'd0, 1'b0);
`else
    for (int k = 2; k <= 205; k++) begin
      step(1'b0, 4'b0010, 4'b0000);
      check($sformatf("hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step(1'b0, 4'b0010, 4'b0010);
    check("late_done", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    check("late_idle", 4'b0000, 2'd0, 1'b0);
`endif

    // Randomized traffic against the reference model.
    rq = '0;
    for (int c = 0; c < 4000; c++) begin
      dn = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(15) == 0) rq[b] = ~rq[b];
        if ($urandom_range(5) == 0) dn[b] = 1'b1;
      end
      step($urandom_range(199) == 0, rq, dn);
      check_model($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
